instr_fetch_unit: RTL and testbench

//  Instruction-fetch stage ahead of the decoder/CU. Owns the PC register and issues in-order

---
 rtl/rv_pkg.sv | 21 ++
 rtl/instr_fetch_unit_if.sv | 30 +++
 rtl/fetch_fifo.sv | 55 +++++
 rtl/instr_fetch_unit.sv | 132 +++++++++++++
 tb/tb_instr_fetch_unit.sv | 228 ++++++++++++++++++++++
 5 files changed

// File: rtl/rv_pkg.sv
// Shared RV32 fetch/decode definitions: NOP encoding, base opcodes and the fetch FSM state type.
package rv_pkg;

    localparam logic [31:0] NOP_INSTR  = 32'h0000_0013;

    localparam logic [6:0]  OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0]  OPC_OP     = 7'b0110011;
    localparam logic [6:0]  OPC_LOAD   = 7'b0000011;
    localparam logic [6:0]  OPC_STORE  = 7'b0100011;
    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH,
        HALT
    } fetch_state_t;

endpackage

// File: rtl/instr_fetch_unit_if.sv
// Instruction-memory req/gnt/rvalid bus plus the valid/ready hand-off to decode.
interface instr_fetch_unit_if #(
    parameter int unsigned XLEN = 32
);
    logic            imem_req_o;
    logic [XLEN-1:0] imem_addr_o;
    logic            imem_gnt_i;
    logic            imem_rvalid_i;
    logic [XLEN-1:0] imem_rdata_i;

    logic            instr_valid_o;
    logic            instr_ready_i;
    logic [XLEN-1:0] instr_o;
    logic [XLEN-1:0] pc_o;
    logic [XLEN-1:0] pc_plus4_o;

    modport master (
        output imem_req_o, imem_addr_o,
        input  imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        output instr_valid_o, instr_o, pc_o, pc_plus4_o,
        input  instr_ready_i
    );

    modport slave (
        input  imem_req_o, imem_addr_o,
        output imem_gnt_i, imem_rvalid_i, imem_rdata_i,
        input  instr_valid_o, instr_o, pc_o, pc_plus4_o,
        output instr_ready_i
    );
endinterface

// File: rtl/fetch_fifo.sv
// Small synchronous FIFO holding fetched {pc, instr} pairs; clear empties it in one cycle.
module fetch_fifo #(
    parameter int unsigned DEPTH = 2,
    parameter int unsigned WIDTH = 64
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic                       pop,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           wdata,
    output logic [WIDTH-1:0]           rdata,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       empty,
    output logic                       full
);
    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    rd_ptr_q, wr_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == AW'(DEPTH - 1)) ? '0 : p + AW'(1);
    endfunction

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign count   = count_q;
    assign rdata   = mem_q[rd_ptr_q];
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
            if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
            count_q <= count_q + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push && !clear) mem_q[wr_ptr_q] <= wdata;
    end
endmodule

// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC, issues in-order word fetches, buffers responses for decode and
// redirects on PCSrc, dropping responses still in flight from the old path.
module instr_fetch_unit
    import rv_pkg::*;
#(
    parameter int unsigned     XLEN       = 32,
    parameter logic [XLEN-1:0] RESET_PC   = '0,
    parameter int unsigned     FIFO_DEPTH = 2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                pc_src_i,
    input  logic [XLEN-1:0]     pc_target_i,
    output logic                fetch_fault_o,
    instr_fetch_unit_if.master  bus
);
    localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);

    fetch_state_t    state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
    logic [CW-1:0]   outstanding_q, outstanding_d, discard_q, discard_d, resp_left, count;
    logic            fault_q, fault_d;
    logic            granted, take, redirect, misaligned;
    logic            push, pop, clear, empty, full;
    logic [XLEN-1:0] head_pc, head_instr, rsp_pc;
    logic [CW:0]     in_use;

    assign granted    = bus.imem_req_o & bus.imem_gnt_i;
    assign take       = bus.instr_valid_o & bus.instr_ready_i;
    assign redirect   = take & pc_src_i;
    assign misaligned = (pc_target_i[1:0] != 2'b00);
    assign in_use     = {1'b0, outstanding_q} + {1'b0, count};
    assign resp_left  = outstanding_q + CW'(granted) - CW'(bus.imem_rvalid_i);
    // Fetches are sequential, so the oldest in-flight word sits 4*outstanding behind fetch_pc.
    assign rsp_pc     = fetch_pc_q - (XLEN'(outstanding_q) << 2);

    fetch_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (2 * XLEN)
    ) u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (push),
        .pop   (pop),
        .clear (clear),
        .wdata ({rsp_pc, bus.imem_rdata_i}),
        .rdata ({head_pc, head_instr}),
        .count (count),
        .empty (empty),
        .full  (full)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:  state_d = RUN;
            RUN: begin
                if (redirect) begin
                    if (misaligned)            state_d = HALT;
                    else if (resp_left != '0)  state_d = FLUSH;
                    else                       state_d = RUN;
                end
            end
            FLUSH: if (discard_q == CW'(bus.imem_rvalid_i)) state_d = RUN;
            HALT:  state_d = HALT;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        bus.imem_req_o    = (state_q == RUN) && (in_use < (CW+1)'(FIFO_DEPTH));
        bus.imem_addr_o   = fetch_pc_q;
        bus.instr_valid_o = (state_q == RUN) && !empty;
        bus.instr_o       = empty ? XLEN'(NOP_INSTR) : head_instr;
        bus.pc_o          = empty ? '0 : head_pc;
        bus.pc_plus4_o    = (empty ? '0 : head_pc) + XLEN'(4);
        fetch_fault_o     = fault_q;
    end

    always_comb begin
        fetch_pc_d    = fetch_pc_q;
        outstanding_d = outstanding_q;
        discard_d     = discard_q;
        fault_d       = fault_q;
        push          = 1'b0;
        pop           = 1'b0;
        clear         = 1'b0;
        unique case (state_q)
            RUN: begin
                if (granted) fetch_pc_d = fetch_pc_q + XLEN'(4);
                outstanding_d = resp_left;
                if (redirect) begin
                    clear         = 1'b1;
                    outstanding_d = '0;
                    if (misaligned) begin
                        fault_d = 1'b1;
                    end else begin
                        fetch_pc_d = pc_target_i;
                        discard_d  = resp_left;
                    end
                end else begin
                    push = bus.imem_rvalid_i;
                    pop  = take;
                end
            end
            FLUSH: if (bus.imem_rvalid_i) discard_d = discard_q - CW'(1);
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q    <= RESET_PC;
            outstanding_q <= '0;
            discard_q     <= '0;
            fault_q       <= 1'b0;
        end else begin
            fetch_pc_q    <= fetch_pc_d;
            outstanding_q <= outstanding_d;
            discard_q     <= discard_d;
            fault_q       <= fault_d;
        end
    end

    // The outstanding cap must keep every push clear of a full buffer.
    assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Randomized bench for instr_fetch_unit: a behavioural memory and an architectural PC-stream
// model decide what decode must see each cycle.
module tb_instr_fetch_unit;
    import rv_pkg::*;

    localparam int unsigned XLEN  = 32;
    localparam logic [31:0] RST_PC = 32'h0000_0000;
    localparam int unsigned DEPTH = 2;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        pc_src = 1'b0;
    logic [31:0] pc_target = '0;
    logic        fault;

    instr_fetch_unit_if #(.XLEN(XLEN)) bus ();

    instr_fetch_unit #(
        .XLEN       (XLEN),
        .RESET_PC   (RST_PC),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .pc_src_i      (pc_src),
        .pc_target_i   (pc_target),
        .fetch_fault_o (fault),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    int          checks = 0;
    int          errors = 0;
    logic [31:0] memq [$];
    logic [31:0] exp_pc, exp_fetch;
    bit          halted, prev_pending;
    int          idle_cnt;

    function automatic logic [31:0] word_at(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h5A5A_3C3C;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        memq.delete();
        exp_pc       = RST_PC;
        exp_fetch    = RST_PC;
        halted       = 1'b0;
        prev_pending = 1'b0;
        idle_cnt     = 0;
    endtask

    task automatic idle_inputs();
        bus.imem_gnt_i    = 1'b0;
        bus.imem_rvalid_i = 1'b0;
        bus.imem_rdata_i  = '0;
        bus.instr_ready_i = 1'b0;
        pc_src            = 1'b0;
        pc_target         = '0;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_req"},   32'(bus.imem_req_o), 0);
        chk({tag, "_addr"},  bus.imem_addr_o, RST_PC);
        chk({tag, "_valid"}, 32'(bus.instr_valid_o), 0);
        chk({tag, "_instr"}, bus.instr_o, NOP_INSTR);
        chk({tag, "_pc"},    bus.pc_o, 0);
        chk({tag, "_pc4"},   bus.pc_plus4_o, 4);
        chk({tag, "_fault"}, 32'(fault), 0);
    endtask

    // Called at a falling edge: check outputs, pick inputs for the next rising edge, advance model.
    task automatic cycle(input int gp, input int rp, input int yp, input int bp,
                         input bit force_rd, input logic [31:0] ftgt);
        logic        req, val;
        logic [31:0] addr, tgt;
        bit          g, rv, rdy, src, take;
        req  = bus.imem_req_o;
        val  = bus.instr_valid_o;
        addr = bus.imem_addr_o;

        if (halted) begin
            chk("halt_fault", 32'(fault), 1);
            chk("halt_req",   32'(req), 0);
            chk("halt_valid", 32'(val), 0);
        end else begin
            chk("fault_low", 32'(fault), 0);
            if (val) begin
                chk("pc",       bus.pc_o, exp_pc);
                chk("instr",    bus.instr_o, word_at(exp_pc));
                chk("pc_plus4", bus.pc_plus4_o, exp_pc + 32'd4);
            end else begin
                chk("empty_instr", bus.instr_o, NOP_INSTR);
                chk("empty_pc",    bus.pc_o, 0);
                chk("empty_pc4",   bus.pc_plus4_o, 4);
            end
            if (req) chk("req_addr", addr, exp_fetch);
            if (prev_pending) chk("req_held", 32'(req), 1);
        end

        g   = ($urandom_range(0, 99) < gp);
        rv  = (memq.size() > 0) && ($urandom_range(0, 99) < rp);
        rdy = ($urandom_range(0, 99) < yp);
        src = val && (force_rd || ($urandom_range(0, 99) < bp));
        if (force_rd) tgt = ftgt;
        else begin
            case ($urandom_range(0, 3))
                0:       tgt = 32'h0000_0100;
                1:       tgt = 32'hFFFF_FFF8;
                default: tgt = $urandom() & 32'hFFFF_FFFC;
            endcase
        end

        bus.imem_gnt_i    = g;
        bus.imem_rvalid_i = rv;
        bus.imem_rdata_i  = rv ? word_at(memq[0]) : $urandom();
        bus.instr_ready_i = rdy;
        pc_src            = src;
        pc_target         = tgt;

        if (rv) void'(memq.pop_front());
        if (req && g) begin
            memq.push_back(addr);
            exp_fetch = addr + 32'd4;
        end
        take         = val && rdy;
        prev_pending = req && !g && !(take && src);
        if (take && !halted) begin
            if (src) begin
                if (tgt[1:0] != 2'b00) halted = 1'b1;
                else begin
                    exp_pc    = tgt;
                    exp_fetch = tgt;
                end
            end else begin
                exp_pc = exp_pc + 32'd4;
            end
        end
        chk("outstanding_cap", 32'(memq.size() <= DEPTH), 1);
        if (!halted) begin
            idle_cnt = take ? 0 : idle_cnt + 1;
            if (idle_cnt > 150) begin
                chk("progress_timeout", idle_cnt, 150);
                idle_cnt = 0;
            end
        end
        @(negedge clk);
    endtask

    task automatic async_reset();
        #2;
        rst_n = 1'b0;
        idle_inputs();
        #1;
        chk_reset_values("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
    endtask

    initial begin
        bit done3, want3;
        idle_inputs();
        model_reset();
        @(negedge clk);
        chk_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;
        done3 = 1'b0;
        want3 = 1'b0;

        for (int k = 0; k < 60; k++) begin
            if (k == 0) chk("t1_idle_req", 32'(bus.imem_req_o), 0);
            if (k == 1) begin
                chk("t1_req_c1",  32'(bus.imem_req_o), 1);
                chk("t1_addr_c1", bus.imem_addr_o, 32'h0);
            end
            if (k == 2) begin
                chk("t1_addr_c2",  bus.imem_addr_o, 32'h4);
                chk("t1_valid_c2", 32'(bus.instr_valid_o), 0);
            end
            if (k == 3) begin
                chk("t1_valid_c3", 32'(bus.instr_valid_o), 1);
                chk("t1_pc_c3",    bus.pc_o, 32'h0);
            end
            if (k == 4) chk("t1_pc_c4", bus.pc_o, 32'h4);
            if (k == 14) begin
                chk("t2_req_full", 32'(bus.imem_req_o), 0);
                chk("t2_valid",    32'(bus.instr_valid_o), 1);
                chk("t2_pc",       bus.pc_o, 32'h8);
            end
            if (want3 && bus.instr_valid_o) begin
                chk("t3_first_after_redirect", bus.pc_o, 32'h100);
                want3 = 1'b0;
            end
            if (!done3 && k >= 20 && bus.instr_valid_o) begin
                done3 = 1'b1;
                want3 = 1'b1;
                cycle(100, 100, 100, 0, 1'b1, 32'h100);
            end else begin
                cycle(100, 100, (k >= 5 && k < 15) ? 0 : 100, 0, 1'b0, 32'h0);
            end
        end

        for (int k = 0; k < 1500; k++) begin
            if (k == 700) async_reset();
            cycle(70, 60, 75, 10, 1'b0, 32'h0);
        end

        for (int k = 0; k < 200 && !halted; k++) cycle(70, 60, 100, 0, 1'b1, 32'h0000_0102);
        chk("t5_fault_reached", 32'(halted), 1);
        for (int k = 0; k < 20; k++) cycle(70, 60, 100, 10, 1'b0, 32'h0);

        async_reset();
        for (int k = 0; k < 300; k++) cycle(70, 60, 75, 10, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
